// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control unit: accepts one instruction per handshake and sequences
// DECODE/EXEC/MEM/WB strobes. Define MIPS_CTRL_ADDI_EN to decode opcode 0x08 as addi.
module mips_ctrl_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_in,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic [31:0] inst,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic [3:0]  ALUcontrol,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        done,
    output logic        illegal
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [5:0] OpAddi  = 6'h08;
`endif

    logic [2:0]  state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic        illegal_q, illegal_d;

    logic [5:0]  opcode, funct;
    logic        dec_legal, dec_regdst, dec_alusrc, dec_memtoreg, dec_lw, dec_sw;
    logic [3:0]  dec_alu;

    assign opcode = inst_q[31:26];
    assign funct  = inst_q[5:0];

    always_comb begin
        dec_legal    = 1'b0;
        dec_regdst   = 1'b0;
        dec_alusrc   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_lw       = 1'b0;
        dec_sw       = 1'b0;
        dec_alu      = 4'b0000;
        case (opcode)
            OpRtype: begin
                dec_regdst = 1'b1;
                dec_legal  = 1'b1;
                case (funct)
                    6'h20:   dec_alu = 4'b0010;
                    6'h22:   dec_alu = 4'b0110;
                    6'h24:   dec_alu = 4'b0000;
                    6'h25:   dec_alu = 4'b0001;
                    6'h2A:   dec_alu = 4'b0111;
                    default: dec_legal = 1'b0;
                endcase
            end
            OpLw: begin
                dec_legal    = 1'b1;
                dec_alu      = 4'b0010;
                dec_alusrc   = 1'b1;
                dec_memtoreg = 1'b1;
                dec_lw       = 1'b1;
            end
            OpSw: begin
                dec_legal  = 1'b1;
                dec_alu    = 4'b0010;
                dec_alusrc = 1'b1;
                dec_sw     = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            OpAddi: begin
                dec_legal  = 1'b1;
                dec_alu    = 4'b0010;
                dec_alusrc = 1'b1;
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        illegal_d = illegal_q;
        case (state_q)
            StIdle: begin
                if (inst_valid) begin
                    inst_d  = inst_in;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    state_d = StExec;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StExec:  state_d = (dec_lw || dec_sw) ? StMem : StWb;
            StMem:   state_d = dec_lw ? StWb : StIdle;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            inst_q    <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            illegal_q <= illegal_d;
        end
    end

    // Everything below depends on state_q and inst_q only, so an asynchronous reset
    // drops every strobe the moment rst_n falls.
    logic active;
    assign active = (state_q != StIdle) && dec_legal;

    always_comb begin
        inst_ready = (state_q == StIdle);
        inst       = inst_q;
        RegDst     = active && dec_regdst;
        ALUSrc     = active && dec_alusrc;
        ALUcontrol = active ? dec_alu : 4'b0000;
        MemToReg   = active && dec_memtoreg;
        MemRead    = dec_legal && dec_lw && ((state_q == StMem) || (state_q == StWb));
        MemWrite   = dec_legal && dec_sw && (state_q == StMem);
        RegWrite   = dec_legal && (state_q == StWb);
        done       = (dec_legal && (state_q == StWb))
                   || (dec_legal && dec_sw && (state_q == StMem))
                   || (!dec_legal && (state_q == StDecode));
        illegal    = illegal_q || (!dec_legal && (state_q == StDecode));
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed self-checking bench for mips_ctrl_fsm; follows MIPS_CTRL_ADDI_EN if defined.
module tb_mips_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, done, illegal;
    logic [3:0]  ALUcontrol;

    int errors = 0;
    int checks = 0;

    mips_ctrl_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_in    (inst_in),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .ALUcontrol (ALUcontrol),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemToReg   (MemToReg),
        .RegWrite   (RegWrite),
        .done       (done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {MemRead, MemWrite, RegWrite, done}
    function automatic logic [3:0] strobes();
        return {MemRead, MemWrite, RegWrite, done};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        inst_in = 32'hDEADBEEF;
        inst_valid = 1'b0;
        #3;
        checks++;
        if ({inst_ready, illegal, strobes()} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got ready/ill/strobes=%b want 100000",
                     {inst_ready, illegal, strobes()});
        end
        checks++;
        if ({inst, RegDst, ALUSrc, ALUcontrol, MemToReg} !== 39'd0) begin
            errors++;
            $display("FAIL reset_dp: got inst=%h RegDst=%b ALUSrc=%b ALU=%b M2R=%b want all 0",
                     inst, RegDst, ALUSrc, ALUcontrol, MemToReg);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        logic [3:0] exp [4] = '{4'b0000, 4'b0000, 4'b0011, 4'b0000};
        inst_in = 32'h00221820;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        checks++;
        if ({inst_ready, inst, RegDst, ALUSrc, ALUcontrol, MemToReg} !==
            {1'b0, 32'h00221820, 1'b1, 1'b0, 4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL add_decode: got rdy=%b inst=%h RegDst=%b ALUSrc=%b ALU=%b M2R=%b want 0 00221820 1 0 0010 0",
                     inst_ready, inst, RegDst, ALUSrc, ALUcontrol, MemToReg);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (strobes() !== exp[i]) begin
                errors++;
                $display("FAIL add_strobe[%0d]: got %b want %b", i, strobes(), exp[i]);
            end
            if (i < 3) tick();
        end
        checks++;
        if ({inst_ready, RegDst, ALUcontrol} !== 6'b100000) begin
            errors++;
            $display("FAIL add_idle: got rdy=%b RegDst=%b ALU=%b want 1 0 0000",
                     inst_ready, RegDst, ALUcontrol);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp [5] = '{4'b0000, 4'b0000, 4'b1000, 4'b1011, 4'b0000};
        inst_in = 32'h8C220004;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (strobes() !== exp[i]) begin
                errors++;
                $display("FAIL lw_strobe[%0d]: got %b want %b", i, strobes(), exp[i]);
            end
            if (i == 3) begin
                checks++;
                if ({MemToReg, ALUSrc, RegDst, ALUcontrol} !== 7'b1100010) begin
                    errors++;
                    $display("FAIL lw_wb_ctrl: got M2R=%b ALUSrc=%b RegDst=%b ALU=%b want 1 1 0 0010",
                             MemToReg, ALUSrc, RegDst, ALUcontrol);
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp [4] = '{4'b0000, 4'b0000, 4'b0101, 4'b0000};
        inst_in = 32'hAC220008;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (strobes() !== exp[i]) begin
                errors++;
                $display("FAIL sw_strobe[%0d]: got %b want %b", i, strobes(), exp[i]);
            end
            if (i == 0) begin
                checks++;
                if ({ALUSrc, RegDst, MemToReg, ALUcontrol} !== 7'b1000010) begin
                    errors++;
                    $display("FAIL sw_ctrl: got ALUSrc=%b RegDst=%b M2R=%b ALU=%b want 1 0 0 0010",
                             ALUSrc, RegDst, MemToReg, ALUcontrol);
                end
            end
            if (i < 3) tick();
        end
        checks++;
        if (inst_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_idle: got inst_ready=%b want 1", inst_ready);
        end
    endtask

    task automatic test_illegal_back_to_back();
        inst_in = 32'hFC000000;
        inst_valid = 1'b1;
        tick();
        checks++;
        if ({illegal, done, MemRead, MemWrite, RegWrite} !== 5'b11000) begin
            errors++;
            $display("FAIL ill_decode: got ill/done/MR/MW/RW=%b want 11000",
                     {illegal, done, MemRead, MemWrite, RegWrite});
        end
        inst_in = 32'h00221822;
        tick();
        checks++;
        if ({inst_ready, illegal, strobes()} !== 6'b110000) begin
            errors++;
            $display("FAIL ill_idle: got rdy/ill/strobes=%b want 110000",
                     {inst_ready, illegal, strobes()});
        end
        tick();
        // Keep valid high with a different word; it must be ignored until IDLE.
        inst_in = 32'h8C220004;
        checks++;
        if ({inst, ALUcontrol, illegal, inst_ready} !== {32'h00221822, 4'b0110, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_decode: got inst=%h ALU=%b ill=%b rdy=%b want 00221822 0110 1 0",
                     inst, ALUcontrol, illegal, inst_ready);
        end
        tick();
        tick();
        checks++;
        if ({inst, RegWrite, done, illegal} !== {32'h00221822, 3'b111}) begin
            errors++;
            $display("FAIL sub_wb: got inst=%h RW=%b done=%b ill=%b want 00221822 1 1 1",
                     inst, RegWrite, done, illegal);
        end
        inst_valid = 1'b0;
        tick();
        checks++;
        if ({inst_ready, illegal, strobes()} !== 6'b110000) begin
            errors++;
            $display("FAIL sub_end: got rdy/ill/strobes=%b want 110000",
                     {inst_ready, illegal, strobes()});
        end
    endtask

    task automatic test_reset_mid_sw();
        inst_in = 32'hAC220008;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL rst_sw_mem: got MemWrite=%b want 1", MemWrite);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({MemWrite, MemRead, RegWrite, done} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async: got MW/MR/RW/done=%b want 0000",
                     {MemWrite, MemRead, RegWrite, done});
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({inst_ready, illegal, inst, RegDst, ALUSrc, ALUcontrol, MemToReg, strobes()} !==
            {1'b1, 1'b0, 32'd0, 11'd0}) begin
            errors++;
            $display("FAIL rst_release: got rdy=%b ill=%b inst=%h RegDst=%b ALUSrc=%b ALU=%b M2R=%b strobes=%b want 1 0 0 all-zero",
                     inst_ready, illegal, inst, RegDst, ALUSrc, ALUcontrol, MemToReg, strobes());
        end
    endtask

    task automatic test_addi();
        inst_in = 32'h20220005;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
`ifdef MIPS_CTRL_ADDI_EN
        checks++;
        if ({ALUSrc, RegDst, MemToReg, ALUcontrol, illegal, done} !== 9'b100001000) begin
            errors++;
            $display("FAIL addi_decode: got ALUSrc=%b RegDst=%b M2R=%b ALU=%b ill=%b done=%b want 1 0 0 0010 0 0",
                     ALUSrc, RegDst, MemToReg, ALUcontrol, illegal, done);
        end
        tick();
        tick();
        checks++;
        if (strobes() !== 4'b0011) begin
            errors++;
            $display("FAIL addi_wb: got strobes=%b want 0011", strobes());
        end
        tick();
`else
        checks++;
        if ({illegal, done, RegWrite, MemWrite, MemRead} !== 5'b11000) begin
            errors++;
            $display("FAIL addi_illegal: got ill/done/RW/MW/MR=%b want 11000",
                     {illegal, done, RegWrite, MemWrite, MemRead});
        end
        tick();
`endif
        checks++;
        if ({inst_ready, RegWrite} !== 2'b10) begin
            errors++;
            $display("FAIL addi_end: got rdy=%b RW=%b want 1 0", inst_ready, RegWrite);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_illegal_back_to_back();
        test_reset_mid_sw();
        test_addi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
